kvadd_ctrl_seq: RTL and testbench

Parametrised kernel-level ap_ctrl sequencer for the kvadd RTL kernel family. It generalises the fixed three-channel start/done/idle glue to NUM_CH channels and adds:
- a per-run channel enable mask;
- ap_ctrl_chain mode (done held until ap_continue);
- a one-deep start queue;
- a run-cycle counter with optional timeout abort.

It sits between the host control registers and the per-port vadd engines.

---
 rtl/kvadd_ctrl_pkg.sv | 13 +
 rtl/kvadd_ctrl_seq_if.sv | 29 ++
 rtl/kvadd_sat_counter.sv | 27 ++
 rtl/kvadd_ctrl_seq.sv | 129 ++++++++++++
 tb/tb_kvadd_ctrl_seq.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/kvadd_ctrl_pkg.sv
// Shared types for the kvadd ap_ctrl sequencer: FSM states and control-protocol modes.
package kvadd_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned MODE_HS    = 0;
  localparam int unsigned MODE_CHAIN = 1;

endpackage

// File: rtl/kvadd_ctrl_seq_if.sv
// Host/engine-facing control bundle of the kvadd sequencer.
// master = host and engine side; slave = the sequencer.
interface kvadd_ctrl_seq_if #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned CNT_W  = 32
);
  logic              ap_start;
  logic              ap_continue;
  logic [NUM_CH-1:0] ch_enable;
  logic [CNT_W-1:0]  timeout_limit;
  logic [NUM_CH-1:0] ch_done;
  logic [NUM_CH-1:0] ch_start;
  logic              ap_idle;
  logic              ap_done;
  logic              ap_ready;
  logic [CNT_W-1:0]  run_cycles;
  logic [NUM_CH-1:0] done_mask;
  logic              timed_out;

  modport master (
    output ap_start, ap_continue, ch_enable, timeout_limit, ch_done,
    input  ch_start, ap_idle, ap_done, ap_ready, run_cycles, done_mask, timed_out
  );

  modport slave (
    input  ap_start, ap_continue, ch_enable, timeout_limit, ch_done,
    output ch_start, ap_idle, ap_done, ap_ready, run_cycles, done_mask, timed_out
  );
endinterface

// File: rtl/kvadd_sat_counter.sv
// Saturating up-counter with synchronous clear (priority over enable) and async reset.
module kvadd_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                  cnt_d = '0;
    else if (en_i && ~&cnt_q)   cnt_d = cnt_q + ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/kvadd_ctrl_seq.sv
// NUM_CH-channel ap_ctrl sequencer: launches enabled vadd engines, collects their
// done pulses, optionally aborts on a cycle limit, and runs the hs/chain handshake.
module kvadd_ctrl_seq
  import kvadd_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned CHAIN_MODE = MODE_HS,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             ap_clk,
  input  logic             areset,
  kvadd_ctrl_seq_if.slave  bus
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t            state_q, state_d;
  logic              start_r_q;
  logic              start_pend_q, start_pend_d;
  logic [NUM_CH-1:0] en_q, en_d;
  logic [CNT_W-1:0]  lim_q, lim_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] done_mask_q, done_mask_d;
  logic              timed_out_q, timed_out_d;
  logic [NUM_CH-1:0] ch_start_q, ch_start_d;
  logic              ap_idle_q, ap_done_q, ap_ready_q;

  logic              start_edge, cont_ok, all_done, tmo_hit, launch;
  logic [NUM_CH-1:0] left;
  logic [CNT_W-1:0]  run_cycles;

  assign start_edge = bus.ap_start & ~start_r_q;
  assign cont_ok    = (CHAIN_MODE == MODE_HS) || bus.ap_continue;
  assign left       = pend_q & ~bus.ch_done;
  assign all_done   = (left == '0);
  // run_cycles is the pre-increment count, so this fires on the lim-th RUN cycle
  assign tmo_hit    = (lim_q != '0) && ((run_cycles + ONE) == lim_q);

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    start_pend_d = start_pend_q;
    en_d         = en_q;
    lim_d        = lim_q;
    pend_d       = pend_q;
    done_mask_d  = done_mask_q;
    timed_out_d  = timed_out_q;
    ch_start_d   = '0;
    launch       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_edge || start_pend_q) begin
          launch       = 1'b1;
          state_d      = RUN;
          en_d         = bus.ch_enable;
          lim_d        = bus.timeout_limit;
          pend_d       = bus.ch_enable;
          done_mask_d  = '0;
          timed_out_d  = 1'b0;
          start_pend_d = 1'b0;
          ch_start_d   = bus.ch_enable;
        end
      end
      RUN: begin
        pend_d      = left;
        done_mask_d = done_mask_q | (bus.ch_done & en_q);
        // completion wins over a coincident timeout
        if (all_done) begin
          state_d = DONE;
        end else if (tmo_hit) begin
          state_d     = DONE;
          timed_out_d = 1'b1;
        end
      end
      DONE: begin
        if (cont_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (start_edge && (state_q != IDLE)) start_pend_d = 1'b1;
  end

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      start_r_q    <= 1'b1;
      start_pend_q <= 1'b0;
      en_q         <= '0;
      lim_q        <= '0;
      pend_q       <= '0;
      done_mask_q  <= '0;
      timed_out_q  <= 1'b0;
      ch_start_q   <= '0;
      ap_idle_q    <= 1'b1;
      ap_done_q    <= 1'b0;
      ap_ready_q   <= 1'b0;
    end else begin
      start_r_q    <= bus.ap_start;
      start_pend_q <= start_pend_d;
      en_q         <= en_d;
      lim_q        <= lim_d;
      pend_q       <= pend_d;
      done_mask_q  <= done_mask_d;
      timed_out_q  <= timed_out_d;
      ch_start_q   <= ch_start_d;
      ap_idle_q    <= (state_d == IDLE);
      ap_done_q    <= (state_d == DONE);
      ap_ready_q   <= (state_d == DONE) && (state_q != DONE);
    end
  end

  kvadd_sat_counter #(.CNT_W(CNT_W)) u_run_cnt (
    .clk   (ap_clk),
    .rst   (areset),
    .clr_i (launch),
    .en_i  (state_q == RUN),
    .cnt_o (run_cycles)
  );

  assign bus.ch_start   = ch_start_q;
  assign bus.ap_idle    = ap_idle_q;
  assign bus.ap_done    = ap_done_q;
  assign bus.ap_ready   = ap_ready_q;
  assign bus.run_cycles = run_cycles;
  assign bus.done_mask  = done_mask_q;
  assign bus.timed_out  = timed_out_q;
endmodule

// File: tb/tb_kvadd_ctrl_seq.sv
// Directed bench: an hs and a chain instance share stimulus; cycle-indexed expectations.
module tb_kvadd_ctrl_seq;
  import kvadd_ctrl_pkg::*;

  localparam int unsigned NCH = 3;
  localparam int unsigned CW  = 8;

  logic           clk = 1'b0;
  logic           areset;
  logic           ap_start, ap_continue;
  logic [NCH-1:0] ch_enable, ch_done;
  logic [CW-1:0]  tlim;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  kvadd_ctrl_seq_if #(.NUM_CH(NCH), .CNT_W(CW)) hs_if ();
  kvadd_ctrl_seq_if #(.NUM_CH(NCH), .CNT_W(CW)) ch_if ();

  assign hs_if.ap_start      = ap_start;
  assign hs_if.ap_continue   = ap_continue;
  assign hs_if.ch_enable     = ch_enable;
  assign hs_if.timeout_limit = tlim;
  assign hs_if.ch_done       = ch_done;
  assign ch_if.ap_start      = ap_start;
  assign ch_if.ap_continue   = ap_continue;
  assign ch_if.ch_enable     = ch_enable;
  assign ch_if.timeout_limit = tlim;
  assign ch_if.ch_done       = ch_done;

  kvadd_ctrl_seq #(.NUM_CH(NCH), .CHAIN_MODE(MODE_HS), .CNT_W(CW)) u_hs (
    .ap_clk (clk),
    .areset (areset),
    .bus    (hs_if.slave)
  );

  kvadd_ctrl_seq #(.NUM_CH(NCH), .CHAIN_MODE(MODE_CHAIN), .CNT_W(CW)) u_ch (
    .ap_clk (clk),
    .areset (areset),
    .bus    (ch_if.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // one call = advance to just after the next rising edge
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic launch(input logic [NCH-1:0] en, input logic [CW-1:0] lim);
    ch_enable = en;
    tlim      = lim;
    ap_start  = 1'b1;
    cyc(1);
    ap_start  = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".start"}, 32'(hs_if.ch_start),   32'd0);
    chk({tag, ".idle"},  32'(hs_if.ap_idle),    32'd1);
    chk({tag, ".done"},  32'(hs_if.ap_done),    32'd0);
    chk({tag, ".ready"}, 32'(hs_if.ap_ready),   32'd0);
    chk({tag, ".rc"},    32'(hs_if.run_cycles), 32'd0);
    chk({tag, ".mask"},  32'(hs_if.done_mask),  32'd0);
    chk({tag, ".tmo"},   32'(hs_if.timed_out),  32'd0);
    chk({tag, ".c_idle"}, 32'(ch_if.ap_idle),   32'd1);
    chk({tag, ".c_done"}, 32'(ch_if.ap_done),   32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1);
  end

  initial begin
    areset = 1'b1; ap_start = 1'b1; ap_continue = 1'b1;
    ch_enable = '0; ch_done = '0; tlim = '0;

    // reset values, with ap_start held high through deassertion
    cyc(2);
    chk_reset_vals("rst");
    areset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cyc(1);
      chk($sformatf("R.start c%0d", c), 32'(hs_if.ch_start), 32'd0);
      chk($sformatf("R.idle c%0d", c),  32'(hs_if.ap_idle),  32'd1);
    end
    ap_start = 1'b0;
    cyc(2);

    // A: hs, all three channels, done at +5 (b0), +9 (b2), +12 (b1)
    launch(3'b111, 8'd0);
    for (int c = 1; c <= 14; c++) begin
      chk($sformatf("A.start c%0d", c), 32'(hs_if.ch_start), (c == 1) ? 32'd7 : 32'd0);
      chk($sformatf("A.idle c%0d", c),  32'(hs_if.ap_idle),  32'(c >= 14));
      chk($sformatf("A.done c%0d", c),  32'(hs_if.ap_done),  32'(c == 13));
      chk($sformatf("A.ready c%0d", c), 32'(hs_if.ap_ready), 32'(c == 13));
      chk($sformatf("A.rc c%0d", c),    32'(hs_if.run_cycles), 32'((c - 1 < 12) ? c - 1 : 12));
      if (c == 10) chk("A.mask10", 32'(hs_if.done_mask), 32'd5);
      if (c == 13) chk("A.mask13", 32'(hs_if.done_mask), 32'd7);
      ch_done = (c == 5) ? 3'b001 : (c == 9) ? 3'b100 : (c == 12) ? 3'b010 : 3'b000;
      cyc(1);
    end
    ch_done = '0;
    cyc(2);

    // B: chain, mask 101, done by +4, continue sampled at +14
    ap_continue = 1'b0;
    launch(3'b101, 8'd0);
    for (int c = 1; c <= 16; c++) begin
      chk($sformatf("B.start c%0d", c), 32'(ch_if.ch_start), (c == 1) ? 32'd5 : 32'd0);
      chk($sformatf("B.done c%0d", c),  32'(ch_if.ap_done),  32'(c >= 5 && c <= 14));
      chk($sformatf("B.ready c%0d", c), 32'(ch_if.ap_ready), 32'(c == 5));
      chk($sformatf("B.idle c%0d", c),  32'(ch_if.ap_idle),  32'(c >= 15));
      chk($sformatf("B.rc c%0d", c),    32'(ch_if.run_cycles), 32'((c - 1 < 4) ? c - 1 : 4));
      if (c == 6) chk("B.mask", 32'(ch_if.done_mask), 32'd5);
      ch_done     = (c == 2) ? 3'b001 : (c == 4) ? 3'b100 : 3'b000;
      ap_continue = (c >= 14);
      cyc(1);
    end
    ap_continue = 1'b1;
    ch_done = '0;
    cyc(2);

    // C: timeout 8, mask 011, only channel 0 reports
    launch(3'b011, 8'd8);
    for (int c = 1; c <= 10; c++) begin
      chk($sformatf("C.done c%0d", c), 32'(hs_if.ap_done),   32'(c == 9));
      chk($sformatf("C.tmo c%0d", c),  32'(hs_if.timed_out), 32'(c >= 9));
      chk($sformatf("C.idle c%0d", c), 32'(hs_if.ap_idle),   32'(c >= 10));
      chk($sformatf("C.rc c%0d", c),   32'(hs_if.run_cycles), 32'((c - 1 < 8) ? c - 1 : 8));
      if (c == 9) chk("C.mask", 32'(hs_if.done_mask), 32'd1);
      ch_done = (c == 3) ? 3'b001 : 3'b000;
      cyc(1);
    end
    ch_done = '0;
    cyc(1);

    // D: edge during RUN queues one launch; the second edge is dropped
    launch(3'b001, 8'd0);
    for (int c = 1; c <= 15; c++) begin
      chk($sformatf("D.start c%0d", c), 32'(hs_if.ch_start), (c == 1 || c == 9) ? 32'd1 : 32'd0);
      chk($sformatf("D.idle c%0d", c),  32'(hs_if.ap_idle),  32'(c == 8 || c >= 12));
      chk($sformatf("D.done c%0d", c),  32'(hs_if.ap_done),  32'(c == 7 || c == 11));
      if (c == 1) chk("D.tmo_clr", 32'(hs_if.timed_out), 32'd0);
      ap_start = (c == 2 || c == 4);
      ch_done  = (c == 6 || c == 10) ? 3'b001 : 3'b000;
      cyc(1);
    end
    ap_start = 1'b0;
    ch_done  = '0;

    // C2: completion and timeout on the same cycle -> normal completion
    launch(3'b001, 8'd3);
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("C2.done c%0d", c), 32'(hs_if.ap_done),   32'(c == 4));
      chk($sformatf("C2.tmo c%0d", c),  32'(hs_if.timed_out), 32'd0);
      ch_done = (c == 3) ? 3'b001 : 3'b000;
      cyc(1);
    end
    ch_done = '0;
    chk("C2.rc", 32'(hs_if.run_cycles), 32'd3);
    cyc(1);

    // E: empty mask
    launch(3'b000, 8'd0);
    chk("E.start1", 32'(hs_if.ch_start), 32'd0);
    chk("E.idle1",  32'(hs_if.ap_idle),  32'd0);
    cyc(1);
    chk("E.done2",  32'(hs_if.ap_done),  32'd1);
    chk("E.ready2", 32'(hs_if.ap_ready), 32'd1);
    chk("E.rc2",    32'(hs_if.run_cycles), 32'd1);
    cyc(1);
    chk("E.idle3",  32'(hs_if.ap_idle),  32'd1);
    cyc(1);

    // G: run counter saturates at all-ones
    launch(3'b001, 8'd0);
    cyc(259);
    chk("G.rc_sat", 32'(hs_if.run_cycles), 32'd255);
    chk("G.run",    32'(hs_if.ap_idle),    32'd0);
    ch_done = 3'b001;
    cyc(1);
    ch_done = '0;
    chk("G.done",   32'(hs_if.ap_done),    32'd1);
    chk("G.rc_end", 32'(hs_if.run_cycles), 32'd255);
    cyc(2);

    // F: areset mid-run
    launch(3'b111, 8'd0);
    ch_done = 3'b001;
    cyc(1);
    ch_done = 3'b010;
    cyc(1);
    ch_done = '0;
    chk("F.mask_pre", 32'(hs_if.done_mask), 32'd3);
    chk("F.idle_pre", 32'(hs_if.ap_idle),   32'd0);
    areset = 1'b1;
    #1;
    chk_reset_vals("F");
    cyc(1);
    areset = 1'b0;
    cyc(3);
    chk("F.idle_post",  32'(hs_if.ap_idle),  32'd1);
    chk("F.start_post", 32'(hs_if.ch_start), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
